uart_tx: RTL and testbench
==========================

// Module: uart_tx
//
// PURPOSE
//   UART transmitter: accepts one DLEN-bit word per AXI-Stream-style handshake and
//   serialises it on o_txs as 8N1-style frames: start bit, DLEN data bits LSB first,
//   STOP_BITS stop bits.
//   Transmit-side companion to the UART receiver; o_txs connects to the far-end rx input.
//
// PARAMETERS
//   BAUD       25000000   line bit rate, bits/s
//   CLKF       100000000  clk frequency, Hz; CLKF/BAUD must be an integer >= 2
//   DLEN       8          data bits per frame, >= 2
//   STOP_BITS  1          stop bits per frame, 1 or 2
//
// PORTS
//   clk       in   1     system clock; the block's only clock
//   rst       in   1     asynchronous, active-high reset
//   i_tvalid  in   1     upstream word valid
//   o_tready  out  1     block can accept a word (IDLE only)
//   i_tdata   in   DLEN  word to transmit
//   o_txs     out  1     serial line out, idle high
//   o_busy    out  1     frame in progress (any state other than IDLE)
//
// BEHAVIOUR
//   - Bit period: T = CLKF/BAUD cycles.
//     Baud counter counts 0..T-1 and wraps; it is held at 0 in IDLE.
//   - Reset (async assert, sync release): state IDLE; o_txs=1, o_tready=0, o_busy=0.
//     Shift register, baud counter and bit counter are cleared.
//     o_tready rises on the first clk edge after rst deasserts.
//   - All outputs are registered; none is combinational from the inputs.
//   - FSM states:
//     - IDLE: o_tready=1, o_txs=1.
//       Handshake (i_tvalid & o_tready) at edge N: latch i_tdata into the shift register;
//       go to START. o_tready=0 and o_txs=0 from edge N.
//     - START: o_txs=0 for T cycles, then DATA.
//     - DATA: o_txs = shreg[0]. Shift right at each baud wrap.
//       Bit counter runs 0..DLEN-1; after DLEN periods go to STOP.
//     - STOP: o_txs=1 for STOP_BITS*T cycles, then IDLE. o_tready rises on the same edge.
//   - Frame length: (1+DLEN+STOP_BITS)*T cycles from the handshake edge to o_tready high.
//   - Back-to-back: i_tvalid held high gives the next handshake on the first IDLE cycle.
//     That inserts exactly one extra idle-high cycle between frames (stop = STOP_BITS*T+1).
//   - i_tvalid/i_tdata are ignored while o_tready=0; i_tdata may change freely after the handshake.
//   - i_tvalid deasserted in IDLE: o_txs stays 1 indefinitely.
//   - rst mid-frame: o_txs returns to 1 asynchronously and the frame is abandoned.
//     No word is retained.
//   - Illegal state encoding: recover to IDLE on the next edge with o_txs=1.
//   - o_busy = (state != IDLE), registered alongside the state.
//
// TESTING  (BAUD=25M, CLKF=100M -> T=4, DLEN=8, STOP_BITS=1 unless noted)
//   1. Reset, no i_tvalid for 100 cycles -> o_txs=1, o_busy=0, o_tready=1 throughout.
//   2. Send 0xA5 -> o_txs holds 0,1,0,1,0,0,1,0,1,1 for 4 cycles each (start, LSB..MSB, stop);
//      o_tready low for exactly 40 cycles.
//   3. i_tvalid held high; send 0x00 then 0xFF back-to-back ->
//      second start bit begins 41 cycles after the first; 2nd frame data bits all 1.
//   4. Change i_tdata to 0x3C and pulse i_tvalid mid-frame while sending 0x81 ->
//      0x81 is transmitted unaltered; no second handshake until o_tready=1.
//   5. Assert rst during data bit 3 of 0x55 -> o_txs=1 in the same cycle;
//      after release o_tready=1 and the next frame (0x0F) is transmitted correctly.
//   6. STOP_BITS=2, DLEN=7, send 0x7F -> frame is 10 bits, 40 cycles, last 8 cycles high;
//      a loopback into the receiver recovers 0x7F.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: one DLEN-bit word per valid/ready handshake, sent as
// start bit, DLEN data bits LSB first, then STOP_BITS stop bits on o_txs.
module uart_tx #(
    parameter int unsigned BAUD      = 25000000,
    parameter int unsigned CLKF      = 100000000,
    parameter int unsigned DLEN      = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_tvalid,
    output logic            o_tready,
    input  logic [DLEN-1:0] i_tdata,
    output logic            o_txs,
    output logic            o_busy
);

    localparam int unsigned T      = CLKF / BAUD;
    localparam int unsigned BAUD_W = (T > 1) ? $clog2(T) : 1;
    localparam int unsigned BIT_W  = $clog2(DLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DLEN-1:0]   shreg_q, shreg_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              txs_q, txs_d;
    logic              tready_q, tready_d;
    logic              busy_q, busy_d;
    logic              baud_wrap;

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            txs_q    <= 1'b1;
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            txs_q    <= txs_d;
            tready_q <= tready_d;
            busy_q   <= busy_d;
        end
    end

    assign baud_wrap = (baud_q == BAUD_W'(T - 1));

    // Next state; outputs are derived from the next state so they register with it
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        baud_d  = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        bit_d   = bit_q;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (i_tvalid && tready_q) begin
                    shreg_d = i_tdata;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    shreg_d = {1'b0, shreg_q[DLEN-1:1]};
                    if (bit_q == BIT_W'(DLEN - 1)) begin
                        state_d = S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (baud_wrap) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        case (state_d)
            S_START: txs_d = 1'b0;
            S_DATA:  txs_d = shreg_d[0];
            default: txs_d = 1'b1;
        endcase
        tready_d = (state_d == S_IDLE);
        busy_d   = (state_d != S_IDLE);
    end

    assign o_txs    = txs_q;
    assign o_tready = tready_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames plus hand sequences for
// back-to-back, mid-frame input changes, mid-frame reset and a 7E2 loopback.
module tb_uart_tx;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tvalid1, tvalid2;
    logic [7:0] tdata1;
    logic [6:0] tdata2;
    logic       o_tready1, o_txs1, o_busy1;
    logic       o_tready2, o_txs2, o_busy2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_tx #(.BAUD(25000000), .CLKF(100000000), .DLEN(8), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .i_tvalid(tvalid1), .o_tready(o_tready1),
        .i_tdata(tdata1), .o_txs(o_txs1), .o_busy(o_busy1)
    );

    uart_tx #(.BAUD(25000000), .CLKF(100000000), .DLEN(7), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .i_tvalid(tvalid2), .o_tready(o_tready2),
        .i_tdata(tdata2), .o_txs(o_txs2), .o_busy(o_busy2)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit k is the k-th bit on the line
    } vec_t;

    vec_t vecs[6];

    // Receiver model for the 7-data, 2-stop loopback
    logic [6:0] rx_data = '0;
    int         rx_frames = 0;
    int         rx_errors = 0;

    initial begin
        forever begin
            @(negedge o_txs2);
            repeat (2) @(negedge clk);
            if (o_txs2 !== 1'b0) rx_errors++;
            for (int b = 0; b < 7; b++) begin
                repeat (T) @(negedge clk);
                rx_data[b] = o_txs2;
            end
            for (int s = 0; s < 2; s++) begin
                repeat (T) @(negedge clk);
                if (o_txs2 !== 1'b1) rx_errors++;
            end
            rx_frames++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic cur_txs(input bit sel);
        return sel ? o_txs2 : o_txs1;
    endfunction

    function automatic logic cur_rdy(input bit sel);
        return sel ? o_tready2 : o_tready1;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? o_busy2 : o_busy1;
    endfunction

    task automatic wait_ready(input bit sel);
        int i = 0;
        while (cur_rdy(sel) !== 1'b1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("ready_wait", 32'(cur_rdy(sel)), 32'd1);
    endtask

    // Called at the negedge right after the handshake edge; returns at the
    // negedge after the frame should have ended.
    task automatic check_frame(input bit sel, input logic [9:0] frame, input int nbits,
                               input int pulse_at, input string name);
        for (int k = 0; k < nbits * T; k++) begin
            if (pulse_at >= 0 && k == pulse_at) begin
                tvalid1 = 1'b1;
                tdata1  = 8'h3C;
            end
            if (pulse_at >= 0 && k == pulse_at + 1) tvalid1 = 1'b0;
            chk($sformatf("%s_bit%0d_cyc%0d", name, k / T, k), 32'(cur_txs(sel)), 32'(frame[k / T]));
            chk($sformatf("%s_tready_low_cyc%0d", name, k), 32'({cur_rdy(sel), cur_busy(sel)}), 32'b01);
            @(negedge clk);
        end
        chk($sformatf("%s_end_ready", name), 32'({cur_rdy(sel), cur_busy(sel), cur_txs(sel)}), 32'b101);
    endtask

    task automatic send(input bit sel, input logic [7:0] data, input logic [9:0] frame,
                        input int nbits, input int pulse_at, input string name);
        wait_ready(sel);
        if (sel) begin
            tvalid2 = 1'b1;
            tdata2  = data[6:0];
        end else begin
            tvalid1 = 1'b1;
            tdata1  = data;
        end
        @(posedge clk);
        @(negedge clk);
        tvalid1 = 1'b0;
        tvalid2 = 1'b0;
        tdata1  = 8'hEE;
        check_frame(sel, frame, nbits, pulse_at, name);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h3C, 10'b1_00111100_0};
        vecs[4] = '{8'h01, 10'b1_00000001_0};
        vecs[5] = '{8'h80, 10'b1_10000000_0};

        rst     = 1'b1;
        tvalid1 = 1'b0;
        tvalid2 = 1'b0;
        tdata1  = 8'h00;
        tdata2  = 7'h00;

        // Reset state, then idle line with no traffic
        @(negedge clk);
        chk("reset_state", 32'({o_txs1, o_busy1, o_tready1}), 32'b100);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk($sformatf("idle_cyc%0d", c), 32'({o_txs1, o_busy1, o_tready1}), 32'b101);
        end

        // Table of single frames
        for (int v = 0; v < 6; v++) begin
            send(1'b0, vecs[v].data, vecs[v].frame, 10, -1, $sformatf("vec%0d", v));
            @(negedge clk);
        end

        // Back-to-back with valid held high; data change after handshake is ignored
        wait_ready(1'b0);
        tvalid1 = 1'b1;
        tdata1  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        tdata1 = 8'hFF;
        check_frame(1'b0, 10'b1_00000000_0, 10, -1, "b2b_first");
        @(negedge clk);
        tvalid1 = 1'b0;
        check_frame(1'b0, 10'b1_11111111_0, 10, -1, "b2b_second");

        // Mid-frame tdata change and valid pulse are ignored
        send(1'b0, 8'h81, 10'b1_10000001_0, 10, 10, "midpulse");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("midpulse_no_hs_cyc%0d", c), 32'({o_txs1, o_tready1, o_busy1}), 32'b110);
        end

        // Reset during data bit 3 of 0x55
        wait_ready(1'b0);
        tvalid1 = 1'b1;
        tdata1  = 8'h55;
        @(posedge clk);
        @(negedge clk);
        tvalid1 = 1'b0;
        repeat (17) @(negedge clk);
        chk("rst_pre_bit3", 32'(o_txs1), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_txs", 32'({o_txs1, o_busy1, o_tready1}), 32'b100);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 32'({o_txs1, o_busy1, o_tready1}), 32'b101);
        send(1'b0, 8'h0F, 10'b1_00001111_0, 10, -1, "after_rst");

        // 7 data bits, 2 stop bits, with loopback receiver
        send(1'b1, 8'h7F, 10'b11_1111111_0, 10, -1, "d7s2");
        repeat (4) @(negedge clk);
        chk("loop_frames", 32'(rx_frames), 32'd1);
        chk("loop_data", 32'(rx_data), 32'h7F);
        chk("loop_framing", 32'(rx_errors), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
